// File: rtl/dac_ctrl_pkg.sv
// Shared types and constants for the DAC control-bus scheduler.
// The optional shadow filter is enabled by defining DAC_CTRL_SHADOW_EN.
package dac_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT,
      ST_GAP
   } state_e;

   localparam int WORD_W       = 16;
   localparam int ADDR_W       = 7;
   localparam int DATA_W       = 8;
   localparam int SHADOW_BASE  = 16;
   localparam int SHADOW_DEPTH = 16;

   function automatic logic [WORD_W-1:0] make_word(input logic [ADDR_W-1:0] addr,
                                                   input logic [DATA_W-1:0] data);
      return {1'b0, addr, data};
   endfunction

endpackage

// File: rtl/dac_ctrl_sched_if.sv
// Requester-side handshake plus DAC serial bus of the control scheduler.
// Handshake: a write transfers in the cycle where i_req_valid[i] and o_req_ready[i]
// are both high; the requester keeps valid, addr and data stable until then.
interface dac_ctrl_sched_if #(
   parameter int NUM_REQ = 4
);
   import dac_ctrl_pkg::*;

   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ*ADDR_W-1:0] i_req_addr;
   logic [NUM_REQ*DATA_W-1:0] i_req_data;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic                      o_sel_n;
   logic                      o_clock;
   logic                      o_data;
   logic                      o_busy;
   logic [2:0]                o_grant_id;
   state_e                    o_dbg_state;

   modport master (
      output i_req_valid, i_req_addr, i_req_data,
      input  o_req_ready, o_sel_n, o_clock, o_data, o_busy, o_grant_id, o_dbg_state
   );

   modport slave (
      input  i_req_valid, i_req_addr, i_req_data,
      output o_req_ready, o_sel_n, o_clock, o_data, o_busy, o_grant_id, o_dbg_state
   );

endinterface

// File: rtl/dac_ctrl_rr_arb.sv
// Round-robin arbiter: searches from the requester after the last winner;
// the pointer moves to the winner only when the grant is accepted.
module dac_ctrl_rr_arb #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [N-1:0] req_i,
   input  logic         accept_i,
   output logic [N-1:0] gnt_o,
   output logic [2:0]   gnt_idx_o
);

   logic [2:0] ptr_q;
   logic       found;
   int         cand;

   always_comb begin
      gnt_o     = '0;
      gnt_idx_o = '0;
      found     = 1'b0;
      cand      = 0;
      for (int k = 1; k <= N; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= N) cand = cand - N;
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            gnt_idx_o   = 3'(cand);
         end
      end
   end

   // Reset pointer to the last requester so requester 0 wins first.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) ptr_q <= 3'(N - 1);
      else if (accept_i) ptr_q <= gnt_idx_o;
   end

endmodule

// File: rtl/dac_ctrl_sched.sv
// Arbitrates register writes from NUM_REQ requesters onto a 3-wire DAC control bus.
// Define DAC_CTRL_SHADOW_EN to drop writes that repeat the last data of addresses 16..31.
module dac_ctrl_sched
   import dac_ctrl_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CLK_DIV     = 8,
   parameter int GAP_PERIODS = 2
) (
   input logic             i_clk48,
   input logic             i_rst48_n,
   dac_ctrl_sched_if.slave bus
);

   localparam int DIV_W = $clog2(CLK_DIV);

   state_e              state_q, state_d;
   logic [DIV_W-1:0]    div_q;
   logic                fall_tick;
   logic [WORD_W-1:0]   word_q, word_d;
   logic                sel_n_q, sel_n_d;
   logic                data_q, data_d;
   logic [4:0]          bit_cnt_q, bit_cnt_d;
   logic [7:0]          gap_cnt_q, gap_cnt_d;
   logic [2:0]          gid_q;
   logic [NUM_REQ-1:0]  gnt;
   logic [2:0]          gnt_idx;
   logic                accept;
   logic                shadow_hit;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_data;

   assign fall_tick = (div_q == DIV_W'(CLK_DIV - 1));
   assign accept    = i_rst48_n && (state_q == ST_IDLE) && (|bus.i_req_valid);
   assign sel_addr  = bus.i_req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
   assign sel_data  = bus.i_req_data[int'(gnt_idx)*DATA_W +: DATA_W];

   dac_ctrl_rr_arb #(.N(NUM_REQ)) u_arb (
      .clk_i     (i_clk48),
      .rst_n_i   (i_rst48_n),
      .req_i     (bus.i_req_valid),
      .accept_i  (accept),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx)
   );

`ifdef DAC_CTRL_SHADOW_EN
   logic [DATA_W-1:0]       sh_data_q [SHADOW_DEPTH];
   logic [SHADOW_DEPTH-1:0] sh_vld_q;
   logic                    in_win;
   logic [3:0]              sh_idx;

   assign in_win     = (sel_addr >= ADDR_W'(SHADOW_BASE)) &&
                       (sel_addr <  ADDR_W'(SHADOW_BASE + SHADOW_DEPTH));
   assign sh_idx     = 4'(sel_addr - ADDR_W'(SHADOW_BASE));
   assign shadow_hit = in_win && sh_vld_q[sh_idx] && (sh_data_q[sh_idx] == sel_data);

   always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
      if (!i_rst48_n) sh_vld_q <= '0;
      else if (accept && in_win) sh_vld_q[sh_idx] <= 1'b1;
   end

   always_ff @(posedge i_clk48) begin
      if (accept && in_win) sh_data_q[sh_idx] <= sel_data;
   end
`else
   assign shadow_hit = 1'b0;
`endif

   always_ff @(posedge i_clk48 or negedge i_rst48_n) begin
      if (!i_rst48_n) begin
         div_q     <= '0;
         state_q   <= ST_IDLE;
         word_q    <= '0;
         sel_n_q   <= 1'b1;
         data_q    <= 1'b0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         gid_q     <= '0;
      end else begin
         div_q     <= fall_tick ? '0 : div_q + DIV_W'(1);
         state_q   <= state_d;
         word_q    <= word_d;
         sel_n_q   <= sel_n_d;
         data_q    <= data_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         if (accept) gid_q <= gnt_idx;
      end
   end

   // Bus outputs only move on a fall tick; the DAC samples on the rising edge.
   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      sel_n_d   = sel_n_q;
      data_d    = data_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && !shadow_hit) begin
               word_d  = make_word(sel_addr, sel_data);
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (fall_tick) begin
               sel_n_d   = 1'b0;
               data_d    = word_q[WORD_W-1];
               word_d    = {word_q[WORD_W-2:0], 1'b0};
               bit_cnt_d = 5'd1;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            if (fall_tick) begin
               if (bit_cnt_q == 5'(WORD_W)) begin
                  sel_n_d   = 1'b1;
                  data_d    = 1'b0;
                  gap_cnt_d = '0;
                  state_d   = ST_GAP;
               end else begin
                  data_d    = word_q[WORD_W-1];
                  word_d    = {word_q[WORD_W-2:0], 1'b0};
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         ST_GAP: begin
            if (fall_tick) begin
               if (gap_cnt_q == 8'(GAP_PERIODS - 1)) state_d = ST_IDLE;
               else gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.o_req_ready = gnt & {NUM_REQ{accept}};
   assign bus.o_sel_n     = sel_n_q;
   assign bus.o_data      = data_q;
   assign bus.o_clock     = (div_q >= DIV_W'(CLK_DIV / 2));
   assign bus.o_busy      = (state_q != ST_IDLE) || (accept && !shadow_hit);
   assign bus.o_grant_id  = gid_q;
   assign bus.o_dbg_state = state_q;

endmodule

// File: tb/tb_dac_ctrl_sched.sv
// Directed bench for dac_ctrl_sched: a serial-bus decoder and arbitration model
// check every cycle; directed tests pin the model with hand-computed values.
module tb_dac_ctrl_sched;

   localparam int NR  = 4;
   localparam int DIV = 8;
   localparam int GAP = 2;

   logic clk;
   logic rst_n;

   dac_ctrl_sched_if #(.NUM_REQ(NR)) bus ();

   dac_ctrl_sched #(
      .NUM_REQ     (NR),
      .CLK_DIV     (DIV),
      .GAP_PERIODS (GAP)
   ) dut (
      .i_clk48   (clk),
      .i_rst48_n (rst_n),
      .bus       (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard state
   logic [15:0] exp_q [$];
   logic [15:0] rx_log [$];
   int          grant_log [$];
   int          ready_pulses = 0;
   int          rx_bits = 0;
   int          ncyc;
   int          model_ptr;
   int          model_gid;
   logic [7:0]  msh_data [16];
   logic [15:0] msh_vld;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ncyc <= 0;
      else ncyc <= ncyc + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 1; k <= NR; k++) begin
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      end
      return -1;
   endfunction

   function automatic logic [31:0] last_rx();
      if (rx_log.size() == 0) return 32'hDEAD_BEEF;
      return {16'h0, rx_log[rx_log.size()-1]};
   endfunction

   function automatic int get_grant(input int i);
      if (i >= grant_log.size()) return -1;
      return grant_log[i];
   endfunction

   // compare process: decodes the bus and checks outputs every cycle
   initial begin : compare
      logic        prev_clk, prev_sel, first_word, pend;
      logic [15:0] sh;
      int          low_cyc, high_cyc, idx, exp_idx;
      bit          hit;
      prev_clk = 1'b0; prev_sel = 1'b1; first_word = 1'b1; pend = 1'b0;
      sh = '0; low_cyc = 0; high_cyc = 0;
      model_ptr = NR - 1; model_gid = 0; msh_vld = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_sel_n", bus.o_sel_n, 1);
            chk("rst_data", bus.o_data, 0);
            chk("rst_clock", bus.o_clock, 0);
            chk("rst_ready", bus.o_req_ready, 0);
            chk("rst_busy", bus.o_busy, 0);
            chk("rst_grant_id", bus.o_grant_id, 0);
            model_ptr = NR - 1; model_gid = 0; msh_vld = '0;
            exp_q.delete();
            prev_clk = 1'b0; prev_sel = 1'b1; first_word = 1'b1; rx_bits = 0;
            continue;
         end
         chk("clock", bus.o_clock, ((ncyc % DIV) >= DIV / 2) ? 1 : 0);
         if (bus.o_sel_n) chk("data_idle", bus.o_data, 0);
         else chk("busy_during_word", bus.o_busy, 1);
         chk("grant_id", bus.o_grant_id, model_gid);
         if (|bus.o_req_ready) begin
            chk("ready_subset_valid", bus.o_req_ready & ~bus.i_req_valid, 0);
            chk("ready_onehot", $countones(bus.o_req_ready), 1);
            idx = 0;
            for (int i = 0; i < NR; i++) if (bus.o_req_ready[i]) idx = i;
            exp_idx = model_pick(bus.i_req_valid, model_ptr);
            chk("grant_idx", idx, exp_idx);
            model_ptr = idx; model_gid = idx;
            grant_log.push_back(idx);
            ready_pulses++;
            hit = 1'b0;
`ifdef DAC_CTRL_SHADOW_EN
            begin
               int a; logic [7:0] d;
               a = int'(bus.i_req_addr[idx*7 +: 7]);
               d = bus.i_req_data[idx*8 +: 8];
               if (a >= 16 && a < 32) begin
                  hit = msh_vld[a-16] && (msh_data[a-16] == d);
                  msh_vld[a-16] = 1'b1; msh_data[a-16] = d;
               end
            end
`endif
            if (!hit) exp_q.push_back({1'b0, bus.i_req_addr[idx*7 +: 7], bus.i_req_data[idx*8 +: 8]});
         end
         if (prev_sel && !bus.o_sel_n) begin
            if (!first_word) begin
               chk("gap_min", (high_cyc >= GAP * DIV) ? 1 : 0, 1);
               if (pend) chk("gap_max", (high_cyc <= (GAP + 1) * DIV) ? 1 : 0, 1);
            end
            rx_bits = 0; low_cyc = 0; sh = '0;
         end
         if (!bus.o_sel_n) begin
            low_cyc++;
            if (!prev_clk && bus.o_clock) begin
               sh = {sh[14:0], bus.o_data};
               rx_bits++;
            end
         end
         if (!prev_sel && bus.o_sel_n) begin
            chk("word_bits", rx_bits, 16);
            chk("sel_low_cycles", low_cyc, 16 * DIV);
            if (exp_q.size() == 0) chk("word_unexpected", sh, 32'hFFFF_FFFF);
            else chk("word", sh, exp_q.pop_front());
            rx_log.push_back(sh);
            high_cyc = 0; first_word = 1'b0; pend = |bus.i_req_valid;
         end
         if (bus.o_sel_n) begin
            high_cyc++;
            if (bus.i_req_valid == '0) pend = 1'b0;
         end
         prev_clk = bus.o_clock;
         prev_sel = bus.o_sel_n;
      end
   end

   // driver tasks
   task automatic send_req(input int ch, input logic [6:0] a, input logic [7:0] d);
      int t;
      bus.i_req_addr[ch*7 +: 7] = a;
      bus.i_req_data[ch*8 +: 8] = d;
      bus.i_req_valid[ch]       = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.o_req_ready[ch] && t < 3000);
      if (!bus.o_req_ready[ch]) chk("ready_timeout", 0, 1);
      @(posedge clk);
      #1 bus.i_req_valid[ch] = 1'b0;
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (t < 5000 && !(exp_q.size() == 0 && bus.o_sel_n && !bus.o_busy && bus.i_req_valid == '0)) begin
         @(negedge clk);
         t++;
      end
      chk("done_timeout", (t < 5000) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin : stimulus
      int n0, p0, t;
      int t2_exp [4];
      int t3_exp [4];
      t2_exp = '{0, 1, 2, 3};
      t3_exp = '{1, 2, 1, 2};
      rst_n = 1'b0;
      bus.i_req_valid = '0;
      bus.i_req_addr  = '0;
      bus.i_req_data  = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // single write 0x10 / 0xA5
      n0 = rx_log.size(); p0 = ready_pulses;
      send_req(0, 7'h10, 8'hA5);
      wait_done();
      chk("t1_word", last_rx(), 32'h10A5);
      chk("t1_word_count", rx_log.size() - n0, 1);
      chk("t1_ready_pulses", ready_pulses - p0, 1);
      chk("t1_busy_after", bus.o_busy, 0);

      // all four requesters at once
      do_reset();
      @(posedge clk); #1;
      grant_log.delete();
      fork
         send_req(0, 7'h01, 8'h11);
         send_req(1, 7'h02, 8'h22);
         send_req(2, 7'h03, 8'h33);
         send_req(3, 7'h04, 8'h44);
      join
      wait_done();
      chk("t2_grants", grant_log.size(), 4);
      for (int i = 0; i < 4; i++) chk("t2_grant_order", get_grant(i), t2_exp[i]);
      chk("t2_last_word", last_rx(), 32'h0444);

      // requester 1 persistently valid against requester 2
      do_reset();
      @(posedge clk); #1;
      grant_log.delete();
      fork
         begin
            send_req(1, 7'h21, 8'h01);
            send_req(1, 7'h21, 8'h02);
         end
         begin
            send_req(2, 7'h22, 8'h03);
            send_req(2, 7'h22, 8'h04);
         end
      join
      wait_done();
      for (int i = 0; i < 4; i++) chk("t3_grant_order", get_grant(i), t3_exp[i]);
      chk("t3_grant_id", bus.o_grant_id, 2);

      // reset in the middle of a word
      do_reset();
      @(posedge clk); #1;
      send_req(3, 7'h33, 8'h5C);
      t = 0;
      while (t < 3000 && rx_bits < 9) begin
         @(negedge clk);
         t++;
      end
      chk("t4_reach_bit7", (rx_bits >= 9) ? 1 : 0, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("t4_sel_n_async", bus.o_sel_n, 1);
      chk("t4_busy_async", bus.o_busy, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n0 = rx_log.size();
      send_req(0, 7'h12, 8'h34);
      wait_done();
      chk("t4_word_after_reset", last_rx(), 32'h1234);
      chk("t4_word_count", rx_log.size() - n0, 1);

      // repeated writes into the shadowed window
      do_reset();
      @(posedge clk); #1;
      n0 = rx_log.size(); p0 = ready_pulses;
      send_req(0, 7'h11, 8'h40);
      send_req(0, 7'h11, 8'h40);
      send_req(0, 7'h11, 8'h41);
      wait_done();
      chk("t5_ready_pulses", ready_pulses - p0, 3);
`ifdef DAC_CTRL_SHADOW_EN
      chk("t5_word_count", rx_log.size() - n0, 2);
`else
      chk("t5_word_count", rx_log.size() - n0, 3);
`endif
      chk("t5_last_word", last_rx(), 32'h1141);
      chk("final_queue_empty", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
